// File: rtl/kp_pkg.sv
`default_nettype none
// ============================================================================
// Module : kp_pkg
// Brief  : Shared types, frame classifier and calculator token constants for
//          the keypad matrix scanner.
// Rev    : 1.0 - initial release
// ============================================================================
package kp_pkg;

  // Widest keypad the classifier accepts (ROWS*COLS must not exceed this)
  localparam int KP_MAX_KEYS = 64;
  localparam int KP_CODE_W   = 6;

  typedef enum logic [1:0] {
    KP_NONE   = 2'd0,
    KP_SINGLE = 2'd1,
    KP_MULTI  = 2'd2
  } kp_class_t;

  typedef enum logic [1:0] {
    KP_DISARMED = 2'd0,
    KP_ARMED    = 2'd1,
    KP_HELD     = 2'd2
  } kp_state_t;

  typedef struct packed {
    kp_class_t              cls;
    logic [KP_CODE_W-1:0]   code;
  } kp_result_t;

  // Calculator token values seen by the decode logic (digits use 4'h0-4'h9)
  localparam logic [3:0] KP_TOK_ADD  = 4'hA;
  localparam logic [3:0] KP_TOK_SUB  = 4'hB;
  localparam logic [3:0] KP_TOK_MUL  = 4'hC;
  localparam logic [3:0] KP_TOK_HASH = 4'hD;
  localparam logic [3:0] KP_TOK_EQ   = 4'hE;

  // Index width for n items; never below one bit
  function automatic int kp_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Classify an active-low frame: no zero, exactly one zero (with its index), or more
  function automatic kp_result_t kp_classify(input logic [KP_MAX_KEYS-1:0] frame);
    kp_result_t res;
    logic       seen;
    logic       multi;
    res.cls  = KP_NONE;
    res.code = '0;
    seen     = 1'b0;
    multi    = 1'b0;
    for (int i = 0; i < KP_MAX_KEYS; i++) begin
      if (!frame[i]) begin
        if (seen) multi = 1'b1;
        else      res.code = KP_CODE_W'(i);
        seen = 1'b1;
      end
    end
    if (multi)     res.cls = KP_MULTI;
    else if (seen) res.cls = KP_SINGLE;
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_col_scan.sv
`default_nettype none
// ============================================================================
// Module : keypad_col_scan
// Brief  : Column sequencer: selects one column at a time, waits SETTLE scan
//          ticks, samples the rows into the frame register, flags frame end.
// Rev    : 1.0 - initial release
// ============================================================================
module keypad_col_scan
  import kp_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int SETTLE = 1
)(
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          ScanTick,
  input  logic [ROWS-1:0]               RowIn,
  output logic [kp_idx_w(COLS)-1:0]     ColSel,
  output logic [ROWS*COLS-1:0]          Frame,
  output logic                          FrameDone
);

  localparam int c_COL_W = kp_idx_w(COLS);
  localparam int c_SET_W = kp_idx_w(SETTLE + 1);

  logic [c_COL_W-1:0]    r_col;
  logic [c_SET_W-1:0]    r_settle;
  logic [ROWS*COLS-1:0]  r_frame;
  logic                  r_frame_done;

  // Column sequencer: settle, then sample and step to the next column on a tick
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_col        <= '0;
      r_settle     <= '0;
      r_frame      <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (ScanTick) begin
        if (r_settle == c_SET_W'(SETTLE)) begin
          r_settle                   <= '0;
          r_frame[r_col*ROWS +: ROWS] <= RowIn;
          r_frame_done               <= (r_col == c_COL_W'(COLS - 1));
          r_col                      <= (r_col == c_COL_W'(COLS - 1)) ? '0 : r_col + c_COL_W'(1);
        end else begin
          r_settle <= r_settle + c_SET_W'(1);
        end
      end
    end
  end

  assign ColSel    = r_col;
  assign Frame     = r_frame;
  assign FrameDone = r_frame_done;

endmodule
`default_nettype wire

// File: rtl/keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module : keypad_matrix_scanner
// Brief  : Matrix keypad front end: column scan, whole-frame debounce with
//          multi-key rejection, optional auto-repeat, KeyRdy/KeyRd handshake.
// Rev    : 1.0 - initial release
// ============================================================================
module keypad_matrix_scanner
  import kp_pkg::*;
#(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int SETTLE    = 1,
  parameter int DEBOUNCE  = 4,
  parameter int REPEAT_EN = 0,
  parameter int REP_DELAY = 32,
  parameter int REP_RATE  = 8
)(
  input  logic                               Clock,
  input  logic                               Reset,
  input  logic                               ScanTick,
  input  logic [ROWS-1:0]                    RowIn,
  output logic [COLS-1:0]                    ColOut,
  output logic                               KeyRdy,
  input  logic                               KeyRd,
  output logic [kp_idx_w(ROWS*COLS)-1:0]     KeyCode,
  output logic                               Overrun
);

  localparam int c_NKEYS   = ROWS * COLS;
  localparam int c_KEY_W   = kp_idx_w(c_NKEYS);
  localparam int c_COL_W   = kp_idx_w(COLS);
  localparam int c_CNT_W   = kp_idx_w(DEBOUNCE + 1);
  localparam int c_REP_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int c_REP_W   = kp_idx_w(c_REP_MAX + 1);

  logic [c_COL_W-1:0]     w_col_sel;
  logic [c_NKEYS-1:0]     w_frame;
  logic                   w_frame_done;
  logic [KP_MAX_KEYS-1:0] w_frame_pad;
  kp_result_t             w_res;
  logic [c_KEY_W-1:0]     w_code;

  kp_state_t              r_state, w_state_nxt;
  logic [c_KEY_W-1:0]     r_cand, w_cand_nxt;
  logic [c_CNT_W-1:0]     r_cnt, w_cnt_nxt, w_cnt_step;
  logic [c_REP_W-1:0]     r_rep, w_rep_nxt, w_rep_step, w_rep_tgt;
  logic                   r_rep_phase, w_phase_nxt;
  logic                   w_same;
  logic                   w_emit;

  keypad_col_scan #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .SETTLE (SETTLE)
  ) u_col_scan (
    .Clock     (Clock),
    .Reset     (Reset),
    .ScanTick  (ScanTick),
    .RowIn     (RowIn),
    .ColSel    (w_col_sel),
    .Frame     (w_frame),
    .FrameDone (w_frame_done)
  );

  // Open-drain column drive: selected column pulled low, the rest released
  for (genvar gi = 0; gi < COLS; gi++) begin : g_col_drive
    assign ColOut[gi] = (w_col_sel == c_COL_W'(gi)) ? 1'b0 : 1'bz;
  end

  // Classify the completed frame; unused classifier inputs read as released keys
  always_comb begin
    w_frame_pad              = '1;
    w_frame_pad[c_NKEYS-1:0] = w_frame;
    w_res                    = kp_classify(w_frame_pad);
    w_code                   = c_KEY_W'(w_res.code);
  end

  // Debounce state register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state     <= KP_DISARMED;
      r_cand      <= '0;
      r_cnt       <= '0;
      r_rep       <= '0;
      r_rep_phase <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cand      <= w_cand_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rep       <= w_rep_nxt;
      r_rep_phase <= w_phase_nxt;
    end
  end

  // Debounce next state: only a classified frame moves the FSM
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_rep_nxt   = r_rep;
    w_phase_nxt = r_rep_phase;
    w_same      = (w_res.cls == KP_SINGLE) && (w_code == r_cand);
    w_cnt_step  = !w_same ? c_CNT_W'(1) :
                  (r_cnt == c_CNT_W'(DEBOUNCE)) ? r_cnt : r_cnt + c_CNT_W'(1);
    w_rep_step  = (r_rep == c_REP_W'(c_REP_MAX)) ? r_rep : r_rep + c_REP_W'(1);
    w_rep_tgt   = r_rep_phase ? c_REP_W'(REP_RATE) : c_REP_W'(REP_DELAY);
    if (w_frame_done) begin
      case (r_state)
        KP_DISARMED: begin
          if (w_res.cls == KP_NONE) begin
            w_state_nxt = KP_ARMED;
            w_cnt_nxt   = '0;
          end
        end
        KP_ARMED: begin
          case (w_res.cls)
            KP_SINGLE: begin
              w_cand_nxt = w_code;
              w_cnt_nxt  = w_cnt_step;
              if (w_cnt_step == c_CNT_W'(DEBOUNCE)) begin
                w_state_nxt = KP_HELD;
                w_rep_nxt   = '0;
                w_phase_nxt = 1'b0;
              end
            end
            KP_MULTI: begin
              w_cnt_nxt   = '0;
              w_state_nxt = KP_DISARMED;
            end
            default: w_cnt_nxt = '0;
          endcase
        end
        KP_HELD: begin
          if (w_res.cls == KP_NONE) begin
            w_state_nxt = KP_ARMED;
            w_cnt_nxt   = '0;
          end else if (!w_same) begin
            w_state_nxt = KP_DISARMED;
          end else if (REPEAT_EN != 0) begin
            if (w_rep_step == w_rep_tgt) begin
              w_rep_nxt   = '0;
              w_phase_nxt = 1'b1;
            end else begin
              w_rep_nxt   = w_rep_step;
            end
          end
        end
        default: w_state_nxt = KP_DISARMED;
      endcase
    end
  end

  // Emit decision: first debounced report or an auto-repeat point
  always_comb begin
    w_emit = 1'b0;
    if (w_frame_done && (w_res.cls == KP_SINGLE)) begin
      if (r_state == KP_ARMED)
        w_emit = (w_cnt_step == c_CNT_W'(DEBOUNCE));
      else if (r_state == KP_HELD)
        w_emit = (REPEAT_EN != 0) && w_same && (w_rep_step == w_rep_tgt);
    end
  end

  // Consumer handshake: a read in the same cycle frees the slot for the new key
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      KeyRdy  <= 1'b0;
      KeyCode <= '0;
      Overrun <= 1'b0;
    end else if (w_emit) begin
      if (!KeyRdy || KeyRd) begin
        KeyCode <= w_code;
        KeyRdy  <= 1'b1;
      end else begin
        Overrun <= 1'b1;
      end
    end else if (KeyRd && KeyRdy) begin
      KeyRdy  <= 1'b0;
      Overrun <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module : tb_keypad_matrix_scanner
// Brief  : Self-checking bench: a key-matrix model drives two scanners (plain
//          and auto-repeat) frame by frame; a frame-level model predicts the
//          handshake outputs.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_keypad_matrix_scanner;

  localparam int M_DLY  = 2;
  localparam int M_RATE = 1;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        ScanTick;
  logic        KeyRd;
  logic [15:0] keys;
  wire  [3:0]  colout0, colout1;
  logic [3:0]  rowin0, rowin1;
  logic        rdy0, rdy1, ovr0, ovr1;
  logic [3:0]  code0, code1;

  int n_checks = 0;
  int n_errors = 0;

  // model state, index 0 = plain scanner, 1 = auto-repeat scanner
  int   m_mode[2];      // 0 waiting for release, 1 armed, 2 key held
  int   m_cand[2];
  int   m_streak[2];
  int   m_held[2];
  bit   m_rdy[2];
  bit   m_ovr[2];
  int   m_code[2];
  logic [15:0] prev_keys;
  bit   prev_valid;

  always #5 Clock = ~Clock;

  for (genvar gi = 0; gi < 4; gi++) begin : g_pull
    pullup (colout0[gi]);
    pullup (colout1[gi]);
  end

  // Key matrix: a pressed key pulls its row low while its column is driven low
  always_comb begin
    rowin0 = '1;
    rowin1 = '1;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[c*4+r]) begin
          if (colout0[c] == 1'b0) rowin0[r] = 1'b0;
          if (colout1[c] == 1'b0) rowin1[r] = 1'b0;
        end
  end

  keypad_matrix_scanner dut0 (
    .Clock(Clock), .Reset(Reset), .ScanTick(ScanTick), .RowIn(rowin0),
    .ColOut(colout0), .KeyRdy(rdy0), .KeyRd(KeyRd), .KeyCode(code0), .Overrun(ovr0)
  );

  keypad_matrix_scanner #(.REPEAT_EN(1), .REP_DELAY(M_DLY), .REP_RATE(M_RATE)) dut1 (
    .Clock(Clock), .Reset(Reset), .ScanTick(ScanTick), .RowIn(rowin1),
    .ColOut(colout1), .KeyRdy(rdy1), .KeyRd(KeyRd), .KeyCode(code1), .Overrun(ovr1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_cand[i] = 0; m_streak[i] = 0; m_held[i] = 0;
      m_rdy[i] = 0; m_ovr[i] = 0; m_code[i] = 0;
    end
    prev_valid = 0;
    prev_keys  = '0;
  endtask

  // One clock edge at frame level: optional classification of frame k, optional read
  task automatic model_edge(input bit do_cls, input logic [15:0] k, input bit rd);
    int n, c;
    bit emit;
    n = $countones(k);
    c = 0;
    for (int j = 0; j < 16; j++) if (k[j]) c = j;
    for (int i = 0; i < 2; i++) begin
      emit = 0;
      if (do_cls) begin
        if (m_mode[i] == 0) begin
          if (n == 0) begin m_mode[i] = 1; m_streak[i] = 0; end
        end else if (m_mode[i] == 1) begin
          if (n == 0) m_streak[i] = 0;
          else if (n > 1) begin m_streak[i] = 0; m_mode[i] = 0; end
          else begin
            m_streak[i] = (c == m_cand[i]) ? m_streak[i] + 1 : 1;
            m_cand[i]   = c;
            if (m_streak[i] >= 4) begin emit = 1; m_mode[i] = 2; m_held[i] = 0; end
          end
        end else begin
          if (n == 0) begin m_mode[i] = 1; m_streak[i] = 0; end
          else if (n > 1 || c != m_cand[i]) m_mode[i] = 0;
          else if (i == 1) begin
            m_held[i]++;
            if (m_held[i] >= M_DLY && ((m_held[i] - M_DLY) % M_RATE) == 0) emit = 1;
          end
        end
      end
      if (emit) begin
        if (!m_rdy[i] || rd) begin m_code[i] = c; m_rdy[i] = 1; end
        else m_ovr[i] = 1;
      end else if (rd && m_rdy[i]) begin
        m_rdy[i] = 0;
        m_ovr[i] = 0;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_rdy0"}, 32'(rdy0), 32'(m_rdy[0]));
    chk({tag, "_code0"}, 32'(code0), 32'(m_code[0]));
    chk({tag, "_ovr0"}, 32'(ovr0), 32'(m_ovr[0]));
    chk({tag, "_rdy1"}, 32'(rdy1), 32'(m_rdy[1]));
    chk({tag, "_code1"}, 32'(code1), 32'(m_code[1]));
    chk({tag, "_ovr1"}, 32'(ovr1), 32'(m_ovr[1]));
  endtask

  // One 8-cycle scan frame with key set k; rd: 0 none, 1 read on the classify edge, 2 read one edge later
  task automatic run_frame(input logic [15:0] k, input int rd);
    @(negedge Clock);
    keys  = k;
    KeyRd = (rd == 1);
    @(posedge Clock);
    model_edge(prev_valid, prev_keys, rd == 1);
    #1;
    KeyRd = 1'b0;
    compare_all("frm");
    if (rd == 2) begin
      KeyRd = 1'b1;
      @(posedge Clock);
      model_edge(1'b0, '0, 1'b1);
      #1;
      KeyRd = 1'b0;
      repeat (6) @(posedge Clock);
    end else begin
      repeat (7) @(posedge Clock);
    end
    prev_keys  = k;
    prev_valid = 1;
  endtask

  function automatic logic [15:0] key(input int n);
    logic [15:0] v;
    v = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] cur;
    int t1, t2, a, b, p;
    logic [3:0] prev_col;

    Reset = 1'b0; ScanTick = 1'b1; KeyRd = 1'b0; keys = '0;
    model_reset();
    repeat (3) @(posedge Clock);
    #1;
    chk("rst_col", 32'(colout0), 32'hE);
    chk("rst_rdy", 32'(rdy0), 0);
    chk("rst_code", 32'(code0), 0);
    chk("rst_ovr", 32'(ovr0), 0);
    @(posedge Clock); #2 Reset = 1'b1;

    // 1: idle, hold r1c2 (code 9)
    run_frame('0, 0); run_frame('0, 0);
    for (int i = 0; i < 6; i++) run_frame(key(9), 0);
    chk("t1_code", 32'(code0), 9);
    chk("t1_rdy", 32'(rdy0), 1);
    chk("t1_ovr", 32'(ovr0), 0);
    run_frame('0, 2);
    chk("t1_read", 32'(rdy0), 0);

    // 2: short press, release, full press of key 5
    for (int i = 0; i < 3; i++) run_frame(key(5), 0);
    run_frame('0, 0);
    for (int i = 0; i < 3; i++) run_frame(key(5), 0);
    chk("t2_early", 32'(rdy0), 0);
    run_frame(key(5), 0);
    run_frame(key(5), 0);
    chk("t2_code", 32'(code0), 5);
    run_frame('0, 2);

    // 3: keys 0 and 6 together, then 0 alone, then release and re-press
    for (int i = 0; i < 5; i++) run_frame(key(0) | key(6), 0);
    for (int i = 0; i < 5; i++) run_frame(key(0), 0);
    chk("t3_none", 32'(rdy0), 0);
    run_frame('0, 0);
    for (int i = 0; i < 5; i++) run_frame(key(0), 0);
    chk("t3_rdy", 32'(rdy0), 1);
    run_frame('0, 2);

    // 4: overrun
    for (int i = 0; i < 4; i++) run_frame(key(3), 0);
    run_frame('0, 0);
    for (int i = 0; i < 4; i++) run_frame(key(7), 0);
    run_frame('0, 0);
    chk("t4_code", 32'(code0), 3);
    chk("t4_ovr", 32'(ovr0), 1);
    run_frame('0, 2);
    chk("t4_rdy_clr", 32'(rdy0), 0);
    chk("t4_ovr_clr", 32'(ovr0), 0);

    // 5: auto-repeat with reads coincident with each report
    for (int i = 0; i < 12; i++) run_frame(key(4), 1);
    chk("t5_code", 32'(code1), 4);
    chk("t5_rdy", 32'(rdy1), 1);
    chk("t5_ovr", 32'(ovr1), 0);
    run_frame('0, 2);

    // randomized frames
    cur = '0;
    for (int f = 0; f < 60; f++) begin
      p = $urandom_range(0, 9);
      if (p == 6) cur = '0;
      else if (p == 7 || p == 8) cur = key($urandom_range(0, 15));
      else if (p == 9) begin
        a = $urandom_range(0, 15);
        b = (a + 1 + $urandom_range(0, 14)) % 16;
        cur = key(a) | key(b);
      end
      run_frame(cur, $urandom_range(0, 2));
    end

    // 6: slow scan tick, asynchronous reset mid-frame, frame period
    keys = key(2);
    for (int i = 0; i < 13; i++) begin
      @(negedge Clock); ScanTick = (i % 4 == 0);
    end
    #1 Reset = 1'b0;
    #1;
    chk("t6_col", 32'(colout0), 32'hE);
    chk("t6_rdy", 32'(rdy0), 0);
    chk("t6_code", 32'(code0), 0);
    chk("t6_ovr", 32'(ovr0), 0);
    chk("t6_rdy1", 32'(rdy1), 0);
    @(posedge Clock); #2 Reset = 1'b1;
    t1 = -1; t2 = -1;
    prev_col = colout0;
    for (int i = 0; i < 120; i++) begin
      @(negedge Clock); ScanTick = (i % 4 == 0);
      @(posedge Clock); #1;
      if (colout0 == 4'hE && prev_col == 4'h7) begin
        if (t1 < 0) t1 = i;
        else if (t2 < 0) t2 = i;
      end
      prev_col = colout0;
    end
    chk("t6_wrap_seen", 32'(t2 >= 0), 1);
    chk("t6_period", 32'(t2 - t1), 32);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
